// File: rtl/data_ram_pkg.sv
// Shared constants for the data memory block: bus width, enable polarities
// and the default memory depth used by the CPU MEM stage.
package data_ram_pkg;

   localparam int   REG_BUS_W         = 32;
   localparam int   DATA_MEM_NUM_LOG2 = 10;
   localparam logic CHIP_ENABLE       = 1'b1;
   localparam logic WRITE_ENABLE      = 1'b1;

endpackage : data_ram_pkg

// File: rtl/data_ram_dmem_array.sv
// Word-organised storage: one synchronous write port with per-byte enables
// and one asynchronous (combinational) read port.
module dmem_array
   import data_ram_pkg::*;
#(
   parameter int ADDR_W = DATA_MEM_NUM_LOG2
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [3:0]             be,
   input  logic [ADDR_W-1:0]      waddr,
   input  logic [REG_BUS_W-1:0]   wdata,
   input  logic [ADDR_W-1:0]      raddr,
   output logic [REG_BUS_W-1:0]   rdata
);

   logic [REG_BUS_W-1:0] r_mem [0:(1<<ADDR_W)-1];

   // Byte-lane write: only lanes with their enable set are updated.
   // NOTE: storage has no reset; contents must survive a pipeline reset and a reset port would also block RAM inference.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) r_mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = r_mem[raddr];

endmodule : dmem_array

// File: rtl/data_ram.sv
// Multi-cycle data memory for the CPU MEM stage. A request is captured in
// IDLE, the access happens after WAIT_CYCLES cycles in BUSY, and DONE releases
// the pipeline stall for one cycle before the block accepts a new request.
module data_ram
   import data_ram_pkg::*;
#(
   parameter int ADDR_LOG2   = DATA_MEM_NUM_LOG2,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 Rst_n,
   input  logic                 ce,
   input  logic                 we,
   input  logic [REG_BUS_W-1:0] addr,
   input  logic [3:0]           sel,
   input  logic [REG_BUS_W-1:0] data_i,
   output logic [REG_BUS_W-1:0] data_o,
   output logic                 stall_req_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]           r_state;
   logic [3:0]           r_cnt;
   logic [ADDR_LOG2-1:0] r_addr;
   logic                 r_we;
   logic [3:0]           r_sel;
   logic [REG_BUS_W-1:0] r_data;
   logic [REG_BUS_W-1:0] r_data_o;

   logic                 w_access;
   logic                 w_mem_we;
   logic [REG_BUS_W-1:0] w_rdata;
   logic                 w_unused;

   // Only the word index takes part in addressing; the rest wraps around.
   assign w_unused = ^{addr[REG_BUS_W-1:ADDR_LOG2+2], addr[1:0]};

   // The access edge is the last BUSY cycle; a reset in flight cancels it.
   assign w_access = Rst_n && (r_state == S_BUSY) && (r_cnt == 4'd1);
   assign w_mem_we = w_access && (r_we == WRITE_ENABLE);

   // Stall goes high in the request cycle itself so the pipeline freezes at once.
   assign stall_req_o = Rst_n && (((r_state == S_IDLE) && (ce == CHIP_ENABLE)) ||
                                  (r_state == S_BUSY));
   assign data_o      = r_data_o;

   dmem_array #(
      .ADDR_W (ADDR_LOG2)
   ) u_dmem_array (
      .clk   (clk),
      .we    (w_mem_we),
      .be    (r_sel),
      .waddr (r_addr),
      .wdata (r_data),
      .raddr (r_addr),
      .rdata (w_rdata)
   );

   // Request FSM: capture, count down the access latency, present load data.
   // NOTE: all state here uses <= so every register samples pre-edge values, whatever the statement order.
   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_addr   <= '0;
         r_we     <= 1'b0;
         r_sel    <= 4'd0;
         r_data   <= '0;
         r_data_o <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ce == CHIP_ENABLE) begin
                  r_addr  <= addr[ADDR_LOG2+1:2];
                  r_we    <= we;
                  r_sel   <= sel;
                  r_data  <= data_i;
                  r_cnt   <= 4'(WAIT_CYCLES);
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state <= S_DONE;
                  if (r_we != WRITE_ENABLE) r_data_o <= w_rdata;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule : data_ram
